// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: three requester valid/ready result channels plus the
// two registered register-file write ports driven by the arbiter.
interface wb_arbiter_if;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;

    logic [4:0]  wreg0;
    logic [31:0] wdata0;
    logic        wen0;
    logic [4:0]  wreg1;
    logic [31:0] wdata1;
    logic        wen1;

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready,
        output wreg0, wdata0, wen0,
        output wreg1, wdata1, wen1
    );

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready,
        input  wreg0, wdata0, wen0,
        input  wreg1, wdata1, wen1
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-port writeback arbiter for ALU/LSU/MULDIV results: rotating priority with a
// starvation override. Define WB_ARB_STATS_EN to add the statistics counters.
module wb_arbiter #(
    parameter int unsigned STARVE_MAX = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    wb_arbiter_if.slave bus
`ifdef WB_ARB_STATS_EN
    ,
    input  logic [1:0]  stat_sel,
    output logic [31:0] stat_count
`endif
);
    localparam int N = 3;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [4:0]   rd   [N];
    logic [31:0]  data [N];
    logic [N-1:0] valid;
    logic [N-1:0] eligible;
    logic [N-1:0] zero_rd;
    logic [N-1:0] starved;
    logic [N-1:0] grant_vec;
    logic [N-1:0] ready;

    logic [3:0]   wait_q [N];
    logic [3:0]   wait_d [N];
    logic [1:0]   rr_q;
    logic [1:0]   rr_d;
    logic [1:0]   order [N];

    logic         g0_vld;
    logic         g1_vld;
    logic [1:0]   g0_idx;
    logic [1:0]   g1_idx;
    logic [1:0]   skips;

    logic         wen0_q;
    logic         wen1_q;
    logic [4:0]   wreg0_q;
    logic [4:0]   wreg1_q;
    logic [31:0]  wdata0_q;
    logic [31:0]  wdata1_q;

    assign valid = bus.req_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            assign rd[gi]        = bus.req_rd[5*gi +: 5];
            assign data[gi]      = bus.req_data[32*gi +: 32];
            assign starved[gi]   = (wait_q[gi] == STARVE_LIM);
            assign eligible[gi]  = valid[gi] && (rd[gi] != 5'd0);
            assign zero_rd[gi]   = valid[gi] && (rd[gi] == 5'd0);
            assign grant_vec[gi] = (g0_vld && (g0_idx == 2'(gi))) ||
                                   (g1_vld && (g1_idx == 2'(gi)));
            // x0 writes are discarded, so they are acknowledged without a port
            assign ready[gi]     = reset_n && (zero_rd[gi] || grant_vec[gi]);
        end
    endgenerate

    assign bus.req_ready = ready;

    // Candidate order: starved requesters by index, then the rotation from rr_q.
    always_comb begin
        logic [1:0] slot;
        logic [2:0] sum;
        logic [1:0] j;
        slot = 2'd0;
        sum  = 3'd0;
        j    = 2'd0;
        for (int k = 0; k < N; k++) begin
            order[k] = 2'(k);
        end
        for (int i = 0; i < N; i++) begin
            if (starved[i]) begin
                order[slot] = 2'(i);
                slot        = slot + 2'd1;
            end
        end
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_q} + 3'(k);
            j   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!starved[j]) begin
                order[slot] = j;
                slot        = slot + 2'd1;
            end
        end
    end

    always_comb begin
        logic [1:0] c;
        c      = 2'd0;
        g0_vld = 1'b0;
        g0_idx = 2'd0;
        g1_vld = 1'b0;
        g1_idx = 2'd0;
        skips  = 2'd0;
        for (int s = 0; s < N; s++) begin
            c = order[s];
            if (eligible[c]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = c;
                end else if (!g1_vld) begin
                    // Never issue two writes to one register in the same cycle
                    if (rd[c] == rd[g0_idx]) begin
                        skips = skips + 2'd1;
                    end else begin
                        g1_vld = 1'b1;
                        g1_idx = c;
                    end
                end
            end
        end
    end

    function automatic logic [1:0] next_idx(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    always_comb begin
        rr_d = rr_q;
        if (g1_vld) begin
            rr_d = next_idx(g1_idx);
        end else if (g0_vld) begin
            rr_d = next_idx(g0_idx);
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (!valid[i] || ready[i]) begin
                wait_d[i] = 4'd0;
            end else if (wait_q[i] == STARVE_LIM) begin
                wait_d[i] = wait_q[i];
            end else begin
                wait_d[i] = wait_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_q     <= 2'd0;
            for (int i = 0; i < N; i++) begin
                wait_q[i] <= 4'd0;
            end
            wen0_q   <= 1'b0;
            wreg0_q  <= 5'd0;
            wdata0_q <= 32'd0;
            wen1_q   <= 1'b0;
            wreg1_q  <= 5'd0;
            wdata1_q <= 32'd0;
        end else begin
            rr_q     <= rr_d;
            for (int i = 0; i < N; i++) begin
                wait_q[i] <= wait_d[i];
            end
            wen0_q   <= g0_vld;
            wreg0_q  <= g0_vld ? rd[g0_idx]   : 5'd0;
            wdata0_q <= g0_vld ? data[g0_idx] : 32'd0;
            wen1_q   <= g1_vld;
            wreg1_q  <= g1_vld ? rd[g1_idx]   : 5'd0;
            wdata1_q <= g1_vld ? data[g1_idx] : 32'd0;
        end
    end

    assign bus.wen0   = wen0_q;
    assign bus.wreg0  = wreg0_q;
    assign bus.wdata0 = wdata0_q;
    assign bus.wen1   = wen1_q;
    assign bus.wreg1  = wreg1_q;
    assign bus.wdata1 = wdata1_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_q [3];
    logic [31:0] stat_d [3];

    // 0: port grants, 1: cycles with a denied valid request, 2: same-rd skips
    always_comb begin
        stat_d[0] = stat_q[0] + 32'(g0_vld) + 32'(g1_vld);
        stat_d[1] = stat_q[1] + 32'(|(valid & ~ready));
        stat_d[2] = stat_q[2] + 32'(skips);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                stat_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    always_comb begin
        case (stat_sel)
            2'd0:    stat_count = stat_q[0];
            2'd1:    stat_count = stat_q[1];
            2'd2:    stat_count = stat_q[2];
            default: stat_count = 32'd0;
        endcase
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts ready
// and the registered writes; a negedge monitor pops and compares them.
module tb_wb_arbiter;
    localparam int STARVE = 2;

    logic clk;
    logic reset_n;
    wb_arbiter_if bus();
`ifdef WB_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [31:0] stat_count;
`endif

    wb_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks;
    int errors;

    bit [2:0]  cur_valid;
    bit [4:0]  cur_rd   [3];
    bit [31:0] cur_data [3];
    bit [2:0]  last_acc;

    int        m_rr;
    int        m_wait [3];
    bit [31:0] m_stat [3];

    bit [2:0]  rdy_q [$];
    bit [75:0] wr_q  [$];

    // Monitor: ready is checked in the cycle it is presented, writes one edge later.
    bit [2:0]  mon_exp_r;
    bit [75:0] mon_exp_w;
    bit [75:0] mon_act_w;
    initial begin
        forever begin
            @(negedge clk);
            if (rdy_q.size() > 0) begin
                mon_exp_r = rdy_q.pop_front();
                checks++;
                if (bus.req_ready !== mon_exp_r) begin
                    errors++;
                    $display("FAIL ready @%0t: act=%b exp=%b", $time, bus.req_ready, mon_exp_r);
                end
            end
            if (wr_q.size() > 0) begin
                mon_exp_w = wr_q.pop_front();
                mon_act_w = {bus.wen0, bus.wreg0, bus.wdata0, bus.wen1, bus.wreg1, bus.wdata1};
                checks++;
                if (mon_act_w !== mon_exp_w) begin
                    errors++;
                    $display("FAIL write @%0t: act p0 %b x%0d=%h p1 %b x%0d=%h exp p0 %b x%0d=%h p1 %b x%0d=%h",
                             $time, mon_act_w[75], mon_act_w[74:70], mon_act_w[69:38],
                             mon_act_w[37], mon_act_w[36:32], mon_act_w[31:0],
                             mon_exp_w[75], mon_exp_w[74:70], mon_exp_w[69:38],
                             mon_exp_w[37], mon_exp_w[36:32], mon_exp_w[31:0]);
                end else if (mon_exp_w[75] || mon_exp_w[37]) begin
                    $display("wb @%0t p0 %b x%0d=%h p1 %b x%0d=%h", $time,
                             mon_act_w[75], mon_act_w[74:70], mon_act_w[69:38],
                             mon_act_w[37], mon_act_w[36:32], mon_act_w[31:0]);
                end
            end else if (bus.wen0 === 1'b1 || bus.wen1 === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write @%0t: act wen0=%b wen1=%b exp none", $time, bus.wen0, bus.wen1);
            end
        end
    end

    // One clock of stimulus: drive, predict, push expectations, advance the model.
    task automatic run_cycle(input bit rst_low);
        int cand[$];
        int gr[$];
        int skips;
        int c;
        bit starv[3];
        bit [2:0]  rdy;
        bit [75:0] w;
        reset_n = !rst_low;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid[i]        = cur_valid[i];
            bus.req_rd[5*i +: 5]    = cur_rd[i];
            bus.req_data[32*i +: 32] = cur_data[i];
        end
        skips = 0;
        rdy   = '0;
        w     = '0;
        if (!rst_low) begin
            for (int i = 0; i < 3; i++) begin
                starv[i] = (m_wait[i] == STARVE);
                if (starv[i]) cand.push_back(i);
            end
            for (int k = 0; k < 3; k++) begin
                if (!starv[(m_rr + k) % 3]) cand.push_back((m_rr + k) % 3);
            end
            foreach (cand[n]) begin
                c = cand[n];
                if (cur_valid[c] && cur_rd[c] != 5'd0) begin
                    if (gr.size() == 0) gr.push_back(c);
                    else if (gr.size() == 1) begin
                        if (cur_rd[c] == cur_rd[gr[0]]) skips++;
                        else gr.push_back(c);
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                rdy[i] = cur_valid[i] && (cur_rd[i] == 5'd0 ||
                         (gr.size() > 0 && gr[0] == i) || (gr.size() > 1 && gr[1] == i));
            end
            if (gr.size() > 0) w[75:38] = {1'b1, cur_rd[gr[0]], cur_data[gr[0]]};
            if (gr.size() > 1) w[37:0]  = {1'b1, cur_rd[gr[1]], cur_data[gr[1]]};
        end
        rdy_q.push_back(rdy);
        @(posedge clk);
        wr_q.push_back(w);
        if (rst_low) begin
            m_rr = 0;
            for (int i = 0; i < 3; i++) begin
                m_wait[i] = 0;
                m_stat[i] = 32'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!cur_valid[i] || rdy[i]) m_wait[i] = 0;
                else if (m_wait[i] < STARVE) m_wait[i]++;
            end
            if (gr.size() > 0) m_rr = (gr[gr.size() - 1] + 1) % 3;
            m_stat[0] += 32'(gr.size());
            m_stat[1] += 32'((cur_valid & ~rdy) != 3'b000);
            m_stat[2] += 32'(skips);
        end
        last_acc = rdy;
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit [4:0] r, input bit [31:0] d);
        cur_valid[i] = v;
        cur_rd[i]    = r;
        cur_data[i]  = d;
    endtask

    task automatic drop_accepted();
        cur_valid = cur_valid & ~last_acc;
    endtask

`ifdef WB_ARB_STATS_EN
    task automatic check_stats();
        bit [31:0] exp_s;
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
            exp_s = (s < 3) ? m_stat[s] : 32'd0;
            checks++;
            if (stat_count !== exp_s) begin
                errors++;
                $display("FAIL stat%0d: act=%0d exp=%0d", s, stat_count, exp_s);
            end
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        m_rr      = 0;
        cur_valid = '0;
        last_acc  = '0;
        for (int i = 0; i < 3; i++) begin
            m_wait[i]   = 0;
            m_stat[i]   = 32'd0;
            cur_rd[i]   = 5'd0;
            cur_data[i] = 32'd0;
        end
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
`ifdef WB_ARB_STATS_EN
        stat_sel = 2'd0;
`endif
        @(posedge clk);
        #1;
        run_cycle(1);
        run_cycle(1);

        // Two requests from rr_ptr 0, then a single request
        set_req(0, 1, 5'd3, 32'hA0A0_0003);
        set_req(2, 1, 5'd7, 32'h0707_0707);
        run_cycle(0);
        drop_accepted();
        run_cycle(0);
        set_req(0, 1, 5'd5, 32'h1234_5678);
        run_cycle(0);
        drop_accepted();
        run_cycle(0);

        // Same-rd conflict from a fresh reset
        run_cycle(1);
        set_req(0, 1, 5'd9, 32'h0000_0900);
        set_req(1, 1, 5'd9, 32'h0000_0901);
        set_req(2, 1, 5'd4, 32'h0000_0402);
        run_cycle(0);
        drop_accepted();
`ifdef WB_ARB_STATS_EN
        check_stats();
`endif
        run_cycle(0);
        drop_accepted();
        run_cycle(0);

        // Zero destination alongside two real writes
        set_req(0, 1, 5'd1, 32'hAAAA_0001);
        set_req(1, 1, 5'd0, 32'hDEAD_BEEF);
        set_req(2, 1, 5'd2, 32'hAAAA_0002);
        run_cycle(0);
        drop_accepted();
        run_cycle(0);

        // All three continuously valid with distinct rds
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!cur_valid[i] || last_acc[i]) set_req(i, 1, 5'(10 + i), $urandom);
            end
            run_cycle(0);
        end

        // Reset while all three are valid; they re-present afterwards
        for (int i = 0; i < 3; i++) begin
            if (!cur_valid[i] || last_acc[i]) set_req(i, 1, 5'(20 + i), $urandom);
        end
        run_cycle(1);
        run_cycle(0);
        drop_accepted();

        // Randomised traffic with a narrow rd range to provoke conflicts
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                run_cycle(1);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (!cur_valid[i] || last_acc[i]) begin
                        set_req(i, ($urandom_range(0, 3) != 0),
                                ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3))
                                                            : 5'($urandom_range(0, 31)),
                                $urandom);
                    end
                end
                run_cycle(0);
            end
        end

        cur_valid = '0;
        run_cycle(0);
        run_cycle(0);
`ifdef WB_ARB_STATS_EN
        check_stats();
`endif
        @(negedge clk);
        #1;
        checks++;
        if (rdy_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL drain: act pending ready=%0d write=%0d exp 0", rdy_q.size(), wr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execution units and the two register-file write ports. It accepts results from three requesters (ALU, load/store unit, mul/div) over valid/ready handshakes and grants at most two per cycle. It drives the register file's wreg0/wdata0/wen0 and wreg1/wdata1/wen1 from registered outputs. Rotating priority plus a starvation guard ensure that every requester is eventually written back.

## Interface
- STARVE_MAX, 7: consecutive denied cycles after which a requester is forced to top priority (1..15)
- clk  input  1  clock
- reset_n  input  1  reset, synchronous, active-low
- req_valid  input  3  per-requester result valid; bit 0 = ALU, 1 = LSU, 2 = mul/div
- req_rd  input  15  destination register, requester i at [5i+4:5i]
- req_data  input  96  result data, requester i at [32i+31:32i]
- req_ready  output  3  per-requester accept, combinational
- wreg0  output  5  register-file port 0 destination
- wdata0  output  32  port 0 data
- wen0  output  1  port 0 write enable
- wreg1  output  5  port 1 destination
- wdata1  output  32  port 1 data
- wen1  output  1  port 1 write enable
- stat_sel  input  2  statistics counter select (only with WB_ARB_STATS_EN)
- stat_count  output  32  selected statistics counter (only with WB_ARB_STATS_EN)

## Operation
- Transfer: a transfer occurs when req_valid[i] & req_ready[i] at a posedge.
  - A requester holds valid, rd and data stable until accepted.
  - req_ready never depends on the requester's own ready.
- Zero destination: a valid request with rd == 0 gets ready = 1 immediately. It consumes no port and produces no write.
- Candidate order:
  - Starved requesters (wait counter == STARVE_MAX) come first, lowest index first.
  - The remaining requesters follow in rotating order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- Grant selection: walk the order and grant the first two valid requests with nonzero rd.
  - The first grant goes to port 0, the second to port 1.
- Same-rd conflict: if the second candidate's rd equals the first grant's rd, it is skipped this cycle. The next candidate, if any, may take port 1.
- rr_ptr update:
  - After a cycle with at least one nonzero-rd grant, rr_ptr becomes (index of last granted requester + 1) mod 3.
  - Otherwise rr_ptr is unchanged.
- Wait counter, one per requester, 4-bit:
  - Increments, saturating at STARVE_MAX, when valid & ~ready.
  - Clears on a grant or when valid is low.
- Output register: the port outputs are loaded from the grants every cycle. An unused port gets wen = 0 and wreg/wdata = 0.

## Timing
- Reset values: wen0 = wen1 = 0, wreg0 = wreg1 = 0, wdata0 = wdata1 = 0, rr_ptr = 0, all wait counters 0, all statistics counters 0.
- req_ready = 0 while reset_n is low.
- Latency:
  - A request accepted at posedge k drives wen/wreg/wdata during cycle k+1.
  - The register file writes at posedge k+1.
  - The register reads valid from posedge k+1.
- Throughput: two nonzero-rd writebacks per cycle, sustained.
- Reset mid-operation: a request accepted at the same edge that samples reset_n low is dropped. Outputs are 0 in the following cycle, and requesters re-present after reset.
- Starvation bound: a continuously valid requester is granted within STARVE_MAX+1 cycles. If all three are starved, index order applies.
- Equal-rd rule: two writes to the same rd are never issued in the same cycle.

## Configuration
- WB_ARB_STATS_EN defined:
  - Three 32-bit counters.
  - Counter 0: granted transfers, summed over both ports.
  - Counter 1: cycles in which some valid request was denied.
  - Counter 2: same-rd conflict skips.
  - stat_sel selects the counter, with 3 reading as 0. stat_count is combinational from the counters.
  - Counters wrap at 2^32 and clear on reset.
- WB_ARB_STATS_EN undefined: the stat_sel and stat_count ports are absent, and there are no counter flops.

## Test plan
- Single request: req 0 valid, rd = 5, data = 0x12345678 -> ready[0] = 1. Next cycle wen0 = 1, wreg0 = 5, wdata0 = 0x12345678, and wen1 = 0.
- Two requests: req 0 (rd 3) and req 2 (rd 7) with rr_ptr = 0 -> both ready. Next cycle port 0 carries x3 and port 1 carries x7, and rr_ptr = 0.
- Three requests, held valid for 6 cycles with distinct rds -> each requester is granted at least once every 2 cycles, and no write is ever missing or duplicated.
- Same-rd conflict: req 0 and req 1 both rd = 9, req 2 rd = 4, rr_ptr = 0 -> req 0 and req 2 are granted and req 1 is deferred to the next cycle. stat counter 2 = 1 with WB_ARB_STATS_EN.
- Zero destination: req 1 valid with rd = 0 while req 0 (rd 1) and req 2 (rd 2) are valid -> all three ready. The next cycle shows writes to x1 and x2 only.
- Reset: reset_n driven low for one cycle while three requests are valid -> req_ready = 0 during reset and wen0 = wen1 = 0 in the next cycle. After reset, rr_ptr = 0 and the first grant goes to req 0.
